spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one SPI master (spi_top datapath) between NUM_REQ independent requesters.
- Round-robin arbitration; latches the winner's operation, TX byte and CS wait duration; drives the master's req/din/wait_duration; collects done_tx/done_rx; returns the received byte with a per-requester response pulse.
- Timeout-protected; enforces an idle gap between transactions so CS deasserts cleanly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SPI_TRF_BIT, 8, SPI word width; must match the SPI master.
- TIMEOUT_CYC, 4096, max clk cycles in WAIT before aborting with error.
- GAP_CYC, 4, clk cycles spi_req is held at 2'b00 after each transaction.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_op  in  2*NUM_REQ  per-requester op: 01 TX, 10 RX, 11 full duplex, 00 no-op.
- req_data  in  NUM_REQ*SPI_TRF_BIT  per-requester TX word.
- req_wait  in  8*NUM_REQ  per-requester CS wait duration.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_data  out  SPI_TRF_BIT  received word, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- spi_req  out  2  to master req.
- spi_din  out  SPI_TRF_BIT  to master din.
- spi_wait_duration  out  8  to master wait_duration.
- spi_dout  in  SPI_TRF_BIT  from master dout.
- spi_done_tx  in  1  from master.
- spi_done_rx  in  1  from master.
- busy  out  1  high in any state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, sticky flags 0, counters 0.
- Reset applies mid-transaction with no response pulse. The master's own reset is expected to abort its transfer.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requester fields must be stable while valid is high.
  - A requester may drop valid before ready; nothing is latched in that case.
- Arbitration (IDLE):
  - Search starts at ptr, wraps modulo NUM_REQ; the first valid index wins.
  - req_ready[win] is combinational, same cycle. Op, data and wait are latched; grant_id = win; ptr <= win+1 (wraps).
  - Next state is ISSUE, or RESP if op==00. A no-op completes with rsp_data=0, rsp_err=0 and no SPI activity.
- ISSUE (1 cycle): registered spi_req/spi_din/spi_wait_duration are driven from the latched values and held constant through WAIT. Sticky flags and timer are cleared. Next state WAIT.
- WAIT:
  - sticky_tx |= spi_done_tx; sticky_rx |= spi_done_rx. Flags may arrive in different cycles.
  - Completion condition per op: 01 needs tx; 10 needs rx; 11 needs tx && rx.
  - On completion: capture spi_dout, or 0 for TX-only. Set spi_req=00 and go to RESP with err=0.
  - Timer increments each WAIT cycle. If it reaches TIMEOUT_CYC-1 without completion: spi_req=00, rsp_data=0, err=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP (1 cycle): rsp_valid[grant_id]=1, rsp_data and rsp_err valid. Next state GAP.
- GAP: spi_req=00 for exactly GAP_CYC cycles, then IDLE.
  - Latency from grant to earliest possible next grant = SPI time + 3 + GAP_CYC.
- Done flags that arrive outside WAIT are ignored.
- No more than one transaction is outstanding at any time.
- rsp_data holds its last value between pulses. rsp_valid and req_ready are never asserted together.

Decomposition:
- spi_arb_pkg: op encodings (OP_NOP/OP_TX/OP_RX/OP_FD), state enum (IDLE, ISSUE, WAIT, RESP, GAP), needs_tx/needs_rx helper functions.
- One sub-module: rr_arbiter (NUM_REQ request vector + ptr -> one-hot grant + index, purely combinational). The FSM, timer and latches stay in the top.

Test Plan:
- Single RX on requester 2, wait=5: slave din=8'hA5 -> one req_ready[2] pulse; spi_req=10 until done_rx; rsp_valid[2] with rsp_data=A5, err=0; then spi_req=00 for 4 cycles.
- All 4 requesters valid continuously, full duplex -> grants in order 0,1,2,3,0. Each rsp_data equals the slave byte loaded for that turn; no requester is granted twice in a row.
- Full duplex where the bench model asserts done_tx 3 cycles before done_rx -> response only after done_rx; rsp_data equals the slave word.
- TIMEOUT_CYC=16 with the master stubbed to never signal done -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_data=0; next request serviced normally.
- No-op from requester 1 -> ready, then rsp_valid[1] 1 cycle later; spi_req stays 00 throughout.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously, no rsp_valid; after release, requester 0 wins a tie with requester 3.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared encodings and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TX  = 2'b01;
    localparam logic [1:0] OP_RX  = 2'b10;
    localparam logic [1:0] OP_FD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        GAP
    } arb_state_e;

    function automatic logic needs_tx(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic needs_rx(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Walk from the far end back toward ptr so the nearest request is written last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin grant,
// per-transaction timeout and an enforced idle gap after every transfer.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SPI_TRF_BIT = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][1:0]               req_op,
    input  logic [NUM_REQ-1:0][SPI_TRF_BIT-1:0]   req_data,
    input  logic [NUM_REQ-1:0][7:0]               req_wait,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [SPI_TRF_BIT-1:0]                rsp_data,
    output logic                                  rsp_err,
    output logic [1:0]                            spi_req,
    output logic [SPI_TRF_BIT-1:0]                spi_din,
    output logic [7:0]                            spi_wait_duration,
    input  logic [SPI_TRF_BIT-1:0]                spi_dout,
    input  logic                                  spi_done_tx,
    input  logic                                  spi_done_rx,
    output logic                                  busy,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d, gid_q, gid_d;
    logic [1:0]             op_q, op_d, spi_req_q, spi_req_d;
    logic [SPI_TRF_BIT-1:0] data_q, data_d, spi_din_q, spi_din_d;
    logic [SPI_TRF_BIT-1:0] rsp_data_q, rsp_data_d;
    logic [7:0]             wait_q, wait_d, spi_wait_q, spi_wait_d;
    logic                   tx_q, tx_d, rx_q, rx_d, rsp_err_q, rsp_err_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [GW-1:0]          gap_q, gap_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               tx_seen, rx_seen, txn_done, timed_out;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Done flags may land in different cycles; the current-cycle pulse counts too.
    assign tx_seen   = tx_q | spi_done_tx;
    assign rx_seen   = rx_q | spi_done_rx;
    assign txn_done  = (!needs_tx(op_q) || tx_seen) && (!needs_rx(op_q) || rx_seen);
    assign timed_out = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = (req_op[arb_idx] == OP_NOP) ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (txn_done || timed_out) state_d = RESP;
            RESP:    state_d = GAP;
            GAP:     if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        op_d       = op_q;
        data_d     = data_q;
        wait_d     = wait_q;
        spi_req_d  = spi_req_q;
        spi_din_d  = spi_din_q;
        spi_wait_d = spi_wait_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (arb_any) begin
                op_d   = req_op[arb_idx];
                data_d = req_data[arb_idx];
                wait_d = req_wait[arb_idx];
                gid_d  = arb_idx;
                ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                if (req_op[arb_idx] == OP_NOP) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            ISSUE: begin
                spi_req_d  = op_q;
                spi_din_d  = data_q;
                spi_wait_d = wait_q;
                tx_d       = 1'b0;
                rx_d       = 1'b0;
                timer_d    = '0;
            end
            WAIT: begin
                tx_d = tx_seen;
                rx_d = rx_seen;
                if (txn_done) begin
                    spi_req_d  = OP_NOP;
                    rsp_data_d = needs_rx(op_q) ? spi_dout : '0;
                    rsp_err_d  = 1'b0;
                end else if (timed_out) begin
                    spi_req_d  = OP_NOP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP:    gap_d = '0;
            GAP:     gap_d = gap_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            gid_q      <= '0;
            op_q       <= OP_NOP;
            data_q     <= '0;
            wait_q     <= '0;
            spi_req_q  <= OP_NOP;
            spi_din_q  <= '0;
            spi_wait_q <= '0;
            tx_q       <= 1'b0;
            rx_q       <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            op_q       <= op_d;
            data_q     <= data_d;
            wait_q     <= wait_d;
            spi_req_q  <= spi_req_d;
            spi_din_q  <= spi_din_d;
            spi_wait_q <= spi_wait_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Ready is gated by reset so a held-valid requester sees nothing while in reset.
    always_comb begin
        req_ready = (state_q == IDLE && rst) ? arb_grant : '0;
        rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << gid_q) : '0;
        busy      = (state_q != IDLE);
    end

    assign rsp_data          = rsp_data_q;
    assign rsp_err           = rsp_err_q;
    assign spi_req           = spi_req_q;
    assign spi_din           = spi_din_q;
    assign spi_wait_duration = spi_wait_q;
    assign grant_id          = gid_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a cycle-counting SPI master stub.
module tb_spi_txn_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid, req_ready, rsp_valid;
    logic [3:0][1:0] req_op;
    logic [3:0][7:0] req_data, req_wait;
    logic [7:0]      rsp_data, spi_din, spi_wait_duration, spi_dout;
    logic            rsp_err, spi_done_tx, spi_done_rx, busy;
    logic [1:0]      spi_req, grant_id;

    int vecs = 0;
    int errs = 0;

    logic       slave_en = 1'b1;
    int         tx_at = 1, rx_at = 1;
    logic [7:0] slave_byte = 8'h00;
    int         slave_cyc = 0;

    spi_txn_arbiter #(.NUM_REQ(4), .SPI_TRF_BIT(8), .TIMEOUT_CYC(16), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_wait(req_wait),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_req(spi_req), .spi_din(spi_din), .spi_wait_duration(spi_wait_duration),
        .spi_dout(spi_dout), .spi_done_tx(spi_done_tx), .spi_done_rx(spi_done_rx),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Master stub: pulses done_tx/done_rx on the tx_at/rx_at-th cycle spi_req is active.
    initial begin
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_dout    = 8'h00;
        forever begin
            @(posedge clk); #1;
            spi_done_tx = 1'b0;
            spi_done_rx = 1'b0;
            if (!slave_en || spi_req == 2'b00) slave_cyc = 0;
            else begin
                slave_cyc++;
                if (spi_req[0] && slave_cyc == tx_at) spi_done_tx = 1'b1;
                if (spi_req[1] && slave_cyc == rx_at) begin
                    spi_done_rx = 1'b1;
                    spi_dout    = slave_byte;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Raise valid, wait for ready (bounded), return ready seen; leaves time at grant+1.
    task automatic issue(input int i, input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] w, output logic [3:0] rdy);
        int n;
        req_op[i] = op; req_data[i] = d; req_wait[i] = w; req_valid[i] = 1'b1;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 60) begin tick(); #1; n++; end
        rdy = req_ready;
        tick();
        req_valid[i] = 1'b0;
    endtask

    // Count samples (current one = 1) until rsp_valid, bounded.
    task automatic wait_rsp(output logic [3:0] rv, output int n, output logic spi_any);
        n = 1;
        spi_any = (spi_req != 2'b00);
        while (rsp_valid == 4'b0 && n < 200) begin
            tick(); n++;
            spi_any = spi_any | (spi_req != 2'b00);
        end
        rv = rsp_valid;
    endtask

    task automatic test_reset();
        logic [37:0] outs;
        rst = 1'b0;
        req_valid = 4'b1111; req_op = '0; req_data = '0; req_wait = '0;
        #3;
        outs = {req_ready, rsp_valid, busy, spi_req, spi_din, spi_wait_duration, rsp_data, rsp_err, grant_id};
        vecs++; if (outs !== 38'h0) begin errs++; $display("FAIL reset_outs: got %h expected 0", outs); end
        tick(); tick();
        outs = {req_ready, rsp_valid, busy, spi_req, spi_din, spi_wait_duration, rsp_data, rsp_err, grant_id};
        vecs++; if (outs !== 38'h0) begin errs++; $display("FAIL reset_hold: got %h expected 0", outs); end
        req_valid = 4'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int n; logic [3:0] rv, exp_g; logic sa;
        int order [5] = '{0, 1, 2, 3, 0};
        slave_en = 1'b1; tx_at = 1; rx_at = 2;
        for (int i = 0; i < 4; i++) begin
            req_op[i] = 2'b11; req_data[i] = 8'h10 + 8'(i); req_wait[i] = 8'h20 + 8'(i);
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << order[t];
            #1; n = 0;
            while (req_ready == 4'b0 && n < 60) begin tick(); #1; n++; end
            vecs++; if (req_ready !== exp_g) begin errs++; $display("FAIL rr_grant%0d: got %b expected %b", t, req_ready, exp_g); end
            slave_byte = 8'h60 + 8'(t);
            tick();
            vecs++; if (grant_id !== 2'(order[t])) begin errs++; $display("FAIL rr_gid%0d: got %0d expected %0d", t, grant_id, order[t]); end
            wait_rsp(rv, n, sa);
            vecs++; if (rv !== exp_g) begin errs++; $display("FAIL rr_rsp%0d: got %b expected %b", t, rv, exp_g); end
            vecs++; if (rsp_data !== 8'h60 + 8'(t)) begin errs++; $display("FAIL rr_data%0d: got %h expected %h", t, rsp_data, 8'h60 + 8'(t)); end
            if (t == 4) req_valid = 4'b0;
        end
    endtask

    task automatic test_single_rx();
        int n; logic [3:0] rv, rdy; logic sa;
        tx_at = 1; rx_at = 3; slave_byte = 8'hA5;
        issue(2, 2'b10, 8'h33, 8'd5, rdy);
        vecs++; if (rdy !== 4'b0100) begin errs++; $display("FAIL rx_ready: got %b expected 0100", rdy); end
        vecs++; if (spi_req !== 2'b00) begin errs++; $display("FAIL rx_issue_req: got %b expected 00", spi_req); end
        tick();
        vecs++; if ({spi_req, spi_din, spi_wait_duration} !== {2'b10, 8'h33, 8'd5})
            begin errs++; $display("FAIL rx_drive: got %b/%h/%0d expected 10/33/5", spi_req, spi_din, spi_wait_duration); end
        wait_rsp(rv, n, sa);
        vecs++; if (n !== 4) begin errs++; $display("FAIL rx_latency: got %0d expected 4", n); end
        vecs++; if ({rv, rsp_data, rsp_err} !== {4'b0100, 8'hA5, 1'b0})
            begin errs++; $display("FAIL rx_rsp: got %b/%h/%b expected 0100/a5/0", rv, rsp_data, rsp_err); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vecs++; if ({busy, spi_req, rsp_valid} !== 7'b1000000)
                begin errs++; $display("FAIL rx_gap%0d: got busy=%b req=%b rv=%b expected 1/00/0000", k, busy, spi_req, rsp_valid); end
        end
        tick();
        vecs++; if ({busy, rsp_data} !== {1'b0, 8'hA5}) begin errs++; $display("FAIL rx_idle: got busy=%b data=%h expected 0/a5", busy, rsp_data); end
    endtask

    task automatic test_nop();
        int n; logic [3:0] rv, rdy; logic sa;
        issue(1, 2'b00, 8'hEE, 8'd1, rdy);
        vecs++; if (rdy !== 4'b0010) begin errs++; $display("FAIL nop_ready: got %b expected 0010", rdy); end
        wait_rsp(rv, n, sa);
        vecs++; if (n !== 1) begin errs++; $display("FAIL nop_latency: got %0d expected 1", n); end
        vecs++; if ({rv, rsp_data, rsp_err, sa} !== {4'b0010, 8'h00, 1'b0, 1'b0})
            begin errs++; $display("FAIL nop_rsp: got %b/%h/%b spi=%b expected 0010/00/0 spi=0", rv, rsp_data, rsp_err, sa); end
    endtask

    task automatic test_timeout();
        int n; logic [3:0] rv, rdy; logic sa;
        slave_en = 1'b0;
        issue(3, 2'b01, 8'h77, 8'd2, rdy);
        vecs++; if (rdy !== 4'b1000) begin errs++; $display("FAIL to_ready: got %b expected 1000", rdy); end
        wait_rsp(rv, n, sa);
        vecs++; if (n !== 18) begin errs++; $display("FAIL to_latency: got %0d expected 18", n); end
        vecs++; if ({rv, rsp_data, rsp_err} !== {4'b1000, 8'h00, 1'b1})
            begin errs++; $display("FAIL to_rsp: got %b/%h/%b expected 1000/00/1", rv, rsp_data, rsp_err); end
        slave_en = 1'b1; tx_at = 1; rx_at = 1; slave_byte = 8'hC3;
        issue(0, 2'b11, 8'h11, 8'd3, rdy);
        wait_rsp(rv, n, sa);
        vecs++; if ({rv, rsp_data, rsp_err} !== {4'b0001, 8'hC3, 1'b0} || n !== 3)
            begin errs++; $display("FAIL to_recover: got %b/%h/%b n=%0d expected 0001/c3/0 n=3", rv, rsp_data, rsp_err, n); end
    endtask

    task automatic test_fd_skew();
        int n; logic [3:0] rv, rdy; logic sa;
        slave_en = 1'b1; tx_at = 2; rx_at = 5; slave_byte = 8'h3C;
        issue(1, 2'b11, 8'h5A, 8'd2, rdy);
        wait_rsp(rv, n, sa);
        vecs++; if (n !== 7) begin errs++; $display("FAIL fd_latency: got %0d expected 7", n); end
        vecs++; if ({rv, rsp_data, rsp_err} !== {4'b0010, 8'h3C, 1'b0})
            begin errs++; $display("FAIL fd_rsp: got %b/%h/%b expected 0010/3c/0", rv, rsp_data, rsp_err); end
    endtask

    task automatic test_reset_mid();
        int n; logic [3:0] rv, rdy; logic sa; logic [37:0] outs;
        slave_en = 1'b0;
        issue(2, 2'b10, 8'h99, 8'd4, rdy);
        tick(); tick();
        vecs++; if ({busy, spi_req} !== 3'b110) begin errs++; $display("FAIL mid_wait: got busy=%b req=%b expected 1/10", busy, spi_req); end
        #1;
        req_op[0] = 2'b01; req_op[3] = 2'b01; req_valid = 4'b1001;
        rst = 1'b0;
        #1;
        outs = {req_ready, rsp_valid, busy, spi_req, spi_din, spi_wait_duration, rsp_data, rsp_err, grant_id};
        vecs++; if (outs !== 38'h0) begin errs++; $display("FAIL mid_reset_outs: got %h expected 0", outs); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++; if ({rsp_valid, req_ready, busy} !== 9'h0)
                begin errs++; $display("FAIL mid_reset_hold%0d: got rv=%b rdy=%b busy=%b expected 0", k, rsp_valid, req_ready, busy); end
        end
        slave_en = 1'b1; tx_at = 1;
        rst = 1'b1;
        #1;
        vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_tie: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0;
        vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL mid_gid: got %0d expected 0", grant_id); end
        wait_rsp(rv, n, sa);
        vecs++; if (rv !== 4'b0001) begin errs++; $display("FAIL mid_rsp: got %b expected 0001", rv); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_rx();
        test_nop();
        test_timeout();
        test_fd_skew();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
